// File: rtl/cvw_pkg.sv
// Shared types and sizing for the divide/sqrt issue sequencer.
// Holds the sequencer state encoding and default widths.
package cvw_pkg;

  localparam int XLEN   = 64;
  localparam int DIVB   = 63;
  localparam int NE     = 11;
  localparam int MAXCYC = 128;

  typedef enum logic [1:0] {
    DQ_IDLE,
    DQ_BUSY,
    DQ_DRAIN,
    DQ_DONE
  } divq_state_t;

endpackage

// File: rtl/fdivsqrt_watchdog.sv
// Busy-cycle watchdog: saturating counter, limit compare, sticky flag.
// Clear/Count in; Expired (comb, on the limit-reaching count) and TimeoutErr out.
module fdivsqrt_watchdog #(
  parameter int MAXCYC = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic Clear,
  input  logic Count,
  output logic Expired,
  output logic TimeoutErr
);

  localparam int CW = $clog2(MAXCYC + 1);
  localparam logic [CW-1:0] LAST  = CW'(MAXCYC - 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAXCYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q,  to_d;

  // Expired fires on the count that brings the total to MAXCYC.
  assign Expired = Count & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q | Expired;
    if (Clear)
      cnt_d = '0;
    else if (Count && cnt_q != LIMIT)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign TimeoutErr = to_q;

endmodule

// File: rtl/fdivsqrt_issue_ctrl.sv
// Requester-side sequencer for the FP/int divide-sqrt unit: issues starts,
// stalls E, holds one M-stage result, drains on flush, flags timeouts.
module fdivsqrt_issue_ctrl
  import cvw_pkg::*;
#(
  parameter int XLEN   = cvw_pkg::XLEN,
  parameter int DIVB   = cvw_pkg::DIVB,
  parameter int NE     = cvw_pkg::NE,
  parameter int MAXCYC = cvw_pkg::MAXCYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FDivOpE,
  input  logic            IDivOpE,
  input  logic            FlushE,
  input  logic            StallM,
  input  logic            FDivBusyE,
  input  logic            FDivDoneE,
  input  logic [DIVB:0]   QmM,
  input  logic [NE+1:0]   QeM,
  input  logic            DivStickyM,
  input  logic [XLEN-1:0] FIntDivResultM,
  output logic            FDivStartE,
  output logic            IDivStartE,
  output logic            DivStallE,
  output logic            ResValidM,
  output logic            ResIsIntM,
  output logic [DIVB:0]   ResQmM,
  output logic [NE+1:0]   ResQeM,
  output logic            ResStickyM,
  output logic [XLEN-1:0] ResIntM,
  output logic            TimeoutErr
);

  divq_state_t state_q, state_d;
  logic isint_q, isint_d;
  logic vld_q, vld_d;
  logic go, cap, clr, cnt_en, expired;

  logic            risint_q;
  logic [DIVB:0]   rqm_q;
  logic [NE+1:0]   rqe_q;
  logic            rst_q;
  logic [XLEN-1:0] rint_q;

  fdivsqrt_watchdog #(.MAXCYC(MAXCYC)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .Clear     (clr),
    .Count     (cnt_en),
    .Expired   (expired),
    .TimeoutErr(TimeoutErr)
  );

  always_comb begin
    state_d    = state_q;
    isint_d    = isint_q;
    vld_d      = vld_q;
    go         = 1'b0;
    cap        = 1'b0;
    clr        = 1'b0;
    cnt_en     = 1'b0;
    FDivStartE = 1'b0;
    IDivStartE = 1'b0;
    DivStallE  = 1'b0;
    case (state_q)
      DQ_IDLE: begin
        go         = (FDivOpE | IDivOpE) & ~FlushE;
        FDivStartE = go & FDivOpE;
        IDivStartE = go & IDivOpE & ~FDivOpE;
        DivStallE  = go;
        if (go) begin
          state_d = DQ_BUSY;
          isint_d = ~FDivOpE;
          clr     = 1'b1;
        end
      end
      DQ_BUSY: begin
        DivStallE = 1'b1;
        // Flush outranks a same-cycle done; an in-flight unit must drain.
        if (FlushE) begin
          state_d = FDivBusyE ? DQ_DRAIN : DQ_IDLE;
        end else if (FDivDoneE) begin
          DivStallE = 1'b0;
          cap       = 1'b1;
          vld_d     = 1'b1;
          state_d   = DQ_DONE;
        end else begin
          cnt_en = 1'b1;
          if (expired)
            state_d = DQ_IDLE;
        end
      end
      DQ_DRAIN: begin
        DivStallE = 1'b1;
        if (!FDivBusyE)
          state_d = DQ_IDLE;
      end
      DQ_DONE: begin
        DivStallE = FDivOpE | IDivOpE;
        if (!StallM) begin
          state_d = DQ_IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = DQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DQ_IDLE;
      isint_q  <= 1'b0;
      vld_q    <= 1'b0;
      risint_q <= 1'b0;
      rqm_q    <= '0;
      rqe_q    <= '0;
      rst_q    <= 1'b0;
      rint_q   <= '0;
    end else begin
      state_q <= state_d;
      isint_q <= isint_d;
      vld_q   <= vld_d;
      if (cap) begin
        risint_q <= isint_q;
        rqm_q    <= QmM;
        rqe_q    <= QeM;
        rst_q    <= DivStickyM;
        rint_q   <= FIntDivResultM;
      end
    end
  end

  assign ResValidM  = vld_q;
  assign ResIsIntM  = risint_q;
  assign ResQmM     = rqm_q;
  assign ResQeM     = rqe_q;
  assign ResStickyM = rst_q;
  assign ResIntM    = rint_q;

endmodule

// File: tb/tb_fdivsqrt_issue_ctrl.sv
// Directed bench for fdivsqrt_issue_ctrl with a per-cycle reference model.
// Model tracks op phase, busy count, held result; literals pin key points.
module tb_fdivsqrt_issue_ctrl;

  localparam int MAXC = 128;

  logic clk = 1'b0;
  logic reset;
  logic FDivOpE, IDivOpE, FlushE, StallM, FDivBusyE, FDivDoneE;
  logic [63:0] QmM;
  logic [12:0] QeM;
  logic DivStickyM;
  logic [63:0] FIntDivResultM;
  logic FDivStartE, IDivStartE, DivStallE, ResValidM, ResIsIntM;
  logic [63:0] ResQmM;
  logic [12:0] ResQeM;
  logic ResStickyM;
  logic [63:0] ResIntM;
  logic TimeoutErr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fdivsqrt_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .FDivOpE(FDivOpE), .IDivOpE(IDivOpE),
    .FlushE(FlushE), .StallM(StallM),
    .FDivBusyE(FDivBusyE), .FDivDoneE(FDivDoneE),
    .QmM(QmM), .QeM(QeM), .DivStickyM(DivStickyM),
    .FIntDivResultM(FIntDivResultM),
    .FDivStartE(FDivStartE), .IDivStartE(IDivStartE),
    .DivStallE(DivStallE), .ResValidM(ResValidM),
    .ResIsIntM(ResIsIntM), .ResQmM(ResQmM), .ResQeM(ResQeM),
    .ResStickyM(ResStickyM), .ResIntM(ResIntM),
    .TimeoutErr(TimeoutErr)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle 1=op in flight 2=draining 3=holding result
  typedef struct {
    int          mode;
    bit          isint;
    int          cnt;
    bit          to;
    bit          vld;
    bit          ri;
    logic [63:0] qm;
    logic [12:0] qe;
    bit          st;
    logic [63:0] iv;
  } mdl_t;

  mdl_t m = '{default: 0};
  bit   armed = 1'b0;

  function automatic mdl_t step(mdl_t c);
    mdl_t n = c;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    case (c.mode)
      0: if ((FDivOpE || IDivOpE) && !FlushE) begin
        n.mode = 1; n.isint = !FDivOpE; n.cnt = 0;
      end
      1: if (FlushE) n.mode = FDivBusyE ? 2 : 0;
      else if (FDivDoneE) begin
        n.mode = 3; n.vld = 1; n.ri = c.isint;
        n.qm = QmM; n.qe = QeM; n.st = DivStickyM; n.iv = FIntDivResultM;
      end else begin
        n.cnt = c.cnt + 1;
        if (n.cnt == MAXC) begin n.to = 1; n.mode = 0; end
      end
      2: if (!FDivBusyE) n.mode = 0;
      3: if (!StallM) begin n.mode = 0; n.vld = 0; end
      default: n.mode = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m <= step(m);
    if (reset) armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      bit go, st;
      go = m.mode == 0 && (FDivOpE || IDivOpE) && !FlushE;
      st = go || (m.mode == 1 && !(FDivDoneE && !FlushE)) ||
           m.mode == 2 || (m.mode == 3 && (FDivOpE || IDivOpE));
      chk("m_fstart", 64'(FDivStartE), 64'(go && FDivOpE));
      chk("m_istart", 64'(IDivStartE), 64'(go && IDivOpE && !FDivOpE));
      chk("m_stall",  64'(DivStallE),  64'(st));
      chk("m_valid",  64'(ResValidM),  64'(m.vld));
      chk("m_isint",  64'(ResIsIntM),  64'(m.ri));
      chk("m_qm",     ResQmM,          m.qm);
      chk("m_qe",     64'(ResQeM),     64'(m.qe));
      chk("m_sticky", 64'(ResStickyM), 64'(m.st));
      chk("m_int",    ResIntM,         m.iv);
      chk("m_tout",   64'(TimeoutErr), 64'(m.to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1; FDivOpE = 0; IDivOpE = 0; FlushE = 0; StallM = 0;
    FDivBusyE = 0; FDivDoneE = 0; QmM = 0; QeM = 0;
    DivStickyM = 0; FIntDivResultM = 0;
    tick(); tick();
    chk("rst_valid", 64'(ResValidM), 64'd0);
    chk("rst_tout",  64'(TimeoutErr), 64'd0);
    chk("rst_stall", 64'(DivStallE), 64'd0);
    reset = 0;
    tick();

    // 1: FP op, 30 busy cycles, then done
    FDivOpE = 1; #1;
    chk("s1_start", 64'(FDivStartE), 64'd1);
    chk("s1_istart", 64'(IDivStartE), 64'd0);
    tick();
    FDivOpE = 0; FDivBusyE = 1; #1;
    chk("s1_one_pulse", 64'(FDivStartE), 64'd0);
    repeat (29) tick();
    tick();
    FDivBusyE = 0; FDivDoneE = 1; DivStickyM = 1;
    QmM = 64'h8000_0000_0000_0001; QeM = 13'h3FF; #1;
    chk("s1_stall_done", 64'(DivStallE), 64'd0);
    tick();
    FDivDoneE = 0; QmM = 0; QeM = 0; DivStickyM = 0; #1;
    chk("s1_valid", 64'(ResValidM), 64'd1);
    chk("s1_qm", ResQmM, 64'h8000_0000_0000_0001);
    chk("s1_qe", 64'(ResQeM), 64'h3FF);
    chk("s1_sticky", 64'(ResStickyM), 64'd1);
    tick(); #1;
    chk("s1_release", 64'(ResValidM), 64'd0);

    // 2: integer op finishing one cycle after start
    IDivOpE = 1; #1;
    chk("s2_istart", 64'(IDivStartE), 64'd1);
    tick();
    IDivOpE = 0; FDivDoneE = 1; FIntDivResultM = '1;
    tick();
    FDivDoneE = 0; FIntDivResultM = 0; #1;
    chk("s2_valid", 64'(ResValidM), 64'd1);
    chk("s2_isint", 64'(ResIsIntM), 64'd1);
    chk("s2_int", ResIntM, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // 3: flush on busy cycle 10, drain, stray done ignored
    FDivOpE = 1; tick();
    FDivOpE = 0; FDivBusyE = 1;
    repeat (9) tick();
    FlushE = 1; #1;
    chk("s3_stall_flush", 64'(DivStallE), 64'd1);
    tick();
    FlushE = 0; #1;
    chk("s3_drain_stall", 64'(DivStallE), 64'd1);
    tick();
    FDivBusyE = 0; FDivDoneE = 1; QmM = 64'hBAD; #1;
    chk("s3_drain_stall2", 64'(DivStallE), 64'd1);
    tick();
    FDivDoneE = 0; #1;
    chk("s3_no_valid", 64'(ResValidM), 64'd0);
    chk("s3_idle_stall", 64'(DivStallE), 64'd0);
    FDivOpE = 1; #1;
    chk("s3_restart", 64'(FDivStartE), 64'd1);
    tick();
    FDivOpE = 0; FDivBusyE = 1;
    repeat (2) tick();
    FDivBusyE = 0; FDivDoneE = 1; QmM = 64'h1234;
    tick();
    FDivDoneE = 0; #1;
    chk("s3_valid", 64'(ResValidM), 64'd1);
    chk("s3_qm", ResQmM, 64'h1234);
    tick();

    // 4: flush and done in the same busy cycle
    FDivOpE = 1; tick();
    FDivOpE = 0; FDivBusyE = 1;
    repeat (4) tick();
    FDivBusyE = 0; FDivDoneE = 1; FlushE = 1; QmM = 64'hDEAD; #1;
    chk("s4_stall", 64'(DivStallE), 64'd1);
    tick();
    FDivDoneE = 0; FlushE = 0; #1;
    chk("s4_no_valid", 64'(ResValidM), 64'd0);
    chk("s4_no_cap", ResQmM, 64'h1234);
    chk("s4_idle", 64'(DivStallE), 64'd0);

    // 5: held result under StallM with a waiting op
    FDivOpE = 1; tick();
    FDivOpE = 0; FDivBusyE = 1; tick();
    FDivBusyE = 0; FDivDoneE = 1; StallM = 1; FDivOpE = 1;
    QmM = 64'hA5A5_0000_0000_5A5A; QeM = 13'h0155; #1;
    chk("s5_busy_nostart", 64'(FDivStartE), 64'd0);
    tick();
    FDivDoneE = 0; QmM = '1; QeM = '1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s5_hold_valid", 64'(ResValidM), 64'd1);
      chk("s5_hold_qm", ResQmM, 64'hA5A5_0000_0000_5A5A);
      chk("s5_hold_nostart", 64'(FDivStartE), 64'd0);
      chk("s5_hold_stall", 64'(DivStallE), 64'd1);
      tick();
    end
    StallM = 0; #1;
    chk("s5_last_nostart", 64'(FDivStartE), 64'd0);
    tick(); #1;
    chk("s5_start_after", 64'(FDivStartE), 64'd1);
    chk("s5_cleared", 64'(ResValidM), 64'd0);
    tick();
    FDivOpE = 0; FDivDoneE = 1; QmM = 64'h77;
    tick();
    FDivDoneE = 0; tick();

    // 6: watchdog expiry, then reset mid-operation
    FDivOpE = 1; tick();
    FDivOpE = 0; FDivBusyE = 1;
    repeat (127) tick();
    chk("s6_pre_tout", 64'(TimeoutErr), 64'd0);
    chk("s6_pre_stall", 64'(DivStallE), 64'd1);
    tick();
    chk("s6_tout", 64'(TimeoutErr), 64'd1);
    chk("s6_idle", 64'(DivStallE), 64'd0);
    FDivBusyE = 0; tick();
    chk("s6_sticky", 64'(TimeoutErr), 64'd1);
    FDivOpE = 1; tick();
    FDivOpE = 0; FDivBusyE = 1;
    repeat (3) tick();
    reset = 1; tick();
    chk("s6_rst_valid", 64'(ResValidM), 64'd0);
    chk("s6_rst_tout", 64'(TimeoutErr), 64'd0);
    chk("s6_rst_stall", 64'(DivStallE), 64'd0);
    chk("s6_rst_qm", ResQmM, 64'd0);
    chk("s6_rst_int", ResIntM, 64'd0);
    reset = 0; FDivBusyE = 0; tick();

    // 7: FP wins over int; flush blocks start
    FDivOpE = 1; IDivOpE = 1; FlushE = 1; #1;
    chk("s7_flush_nostart", 64'(FDivStartE), 64'd0);
    chk("s7_flush_nostall", 64'(DivStallE), 64'd0);
    FlushE = 0; #1;
    chk("s7_fp_wins", 64'(FDivStartE), 64'd1);
    chk("s7_int_loses", 64'(IDivStartE), 64'd0);
    tick();
    FDivOpE = 0; IDivOpE = 0; FDivDoneE = 1;
    tick();
    FDivDoneE = 0; #1;
    chk("s7_isint", 64'(ResIsIntM), 64'd0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
